// File: rtl/role_north_axil_csr_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : role_north_axil_csr_if
// Brief    : AXI4-Lite bus bundle between the shell's static master and the
//            NORTH role CSR responder. The master modport drives requests and
//            the slave modport returns handshakes, responses and read data.
// Revision : 1.0  initial release
// ============================================================================
interface role_north_axil_csr_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/role_north_axil_csr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : role_north_axil_csr
// Brief    : AXI4-Lite CSR responder for the NORTH reconfigurable role. Holds
//            DMA source/destination/length registers, generates the start
//            pulse, tracks sticky DONE and a saturating busy-cycle counter.
//            Optional macro ROLE_CSR_SCRATCH_EN adds a R/W SCRATCH register
//            at offset 0x24; without it that offset is unmapped (SLVERR).
// Revision : 1.0  initial release
// ============================================================================
module role_north_axil_csr #(
  parameter logic [31:0] VERSION = 32'h0001_0000
) (
  input  logic                         CLK_IN_250,
  input  logic                         AXI_RESET,
  role_north_axil_csr_if.slave         S_AXI_LITE_NORTH_FROM_STATIC,
  output logic                         ctrl_start,
  output logic [63:0]                  ctrl_src_addr,
  output logic [63:0]                  ctrl_dst_addr,
  output logic [31:0]                  ctrl_len,
  input  logic                         status_busy,
  input  logic                         status_done
);

  // Word indices (byte offset / 4) of the register map.
  localparam logic [5:0] c_idx_ctrl    = 6'd0;
  localparam logic [5:0] c_idx_status  = 6'd1;
  localparam logic [5:0] c_idx_src_lo  = 6'd2;
  localparam logic [5:0] c_idx_src_hi  = 6'd3;
  localparam logic [5:0] c_idx_dst_lo  = 6'd4;
  localparam logic [5:0] c_idx_dst_hi  = 6'd5;
  localparam logic [5:0] c_idx_len     = 6'd6;
  localparam logic [5:0] c_idx_version = 6'd7;
  localparam logic [5:0] c_idx_cnt     = 6'd8;
`ifdef ROLE_CSR_SCRATCH_EN
  localparam logic [5:0] c_idx_scratch = 6'd9;
`endif

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACK = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACK = 2'd1, R_DATA = 2'd2} rstate_t;

  wstate_t     r_wstate;
  rstate_t     r_rstate;

  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_arready;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;

  logic [63:0] r_src;
  logic [63:0] r_dst;
  logic [31:0] r_len;
  logic        r_done;
  logic        r_start;
  logic [31:0] r_cycle_cnt;
`ifdef ROLE_CSR_SCRATCH_EN
  logic [31:0] r_scratch;
`endif

  logic [5:0]  w_waddr_idx;
  logic [5:0]  w_raddr_idx;
  logic        w_wr_commit;
  logic        w_wr_mapped;
  logic [31:0] w_rd_data;
  logic        w_rd_mapped;
  logic        w_start_req;
  logic        w_done_clr;

  assign w_waddr_idx = S_AXI_LITE_NORTH_FROM_STATIC.awaddr[7:2];
  assign w_raddr_idx = S_AXI_LITE_NORTH_FROM_STATIC.araddr[7:2];

  // The register update happens on the edge that ends the W_ACK cycle; the
  // master holds address and data stable until then.
  assign w_wr_commit = (r_wstate == W_ACK);

  assign w_start_req = w_wr_commit && (w_waddr_idx == c_idx_ctrl) &&
                       S_AXI_LITE_NORTH_FROM_STATIC.wdata[0] && !status_busy;
  assign w_done_clr  = w_wr_commit && (w_waddr_idx == c_idx_status) &&
                       S_AXI_LITE_NORTH_FROM_STATIC.wdata[1];

  // Address bits outside [7:2] and the protection fields carry no meaning here.
  logic w_unused_bits;
  assign w_unused_bits = ^{S_AXI_LITE_NORTH_FROM_STATIC.awaddr[31:8],
                           S_AXI_LITE_NORTH_FROM_STATIC.awaddr[1:0],
                           S_AXI_LITE_NORTH_FROM_STATIC.araddr[31:8],
                           S_AXI_LITE_NORTH_FROM_STATIC.araddr[1:0],
                           S_AXI_LITE_NORTH_FROM_STATIC.awprot,
                           S_AXI_LITE_NORTH_FROM_STATIC.arprot};

  // Byte-lane merge of write data into an existing register value.
  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  // Write-side decode: which offsets exist (read-only ones still answer OKAY).
  always_comb begin
    w_wr_mapped = 1'b0;
    case (w_waddr_idx)
      c_idx_ctrl, c_idx_status, c_idx_src_lo, c_idx_src_hi, c_idx_dst_lo,
      c_idx_dst_hi, c_idx_len, c_idx_version, c_idx_cnt: w_wr_mapped = 1'b1;
`ifdef ROLE_CSR_SCRATCH_EN
      c_idx_scratch: w_wr_mapped = 1'b1;
`endif
      default: w_wr_mapped = 1'b0;
    endcase
  end

  // Read-side mux of current register contents; unmapped offsets read zero.
  always_comb begin
    w_rd_data   = 32'h0;
    w_rd_mapped = 1'b1;
    case (w_raddr_idx)
      c_idx_ctrl:    w_rd_data = 32'h0;
      c_idx_status:  w_rd_data = {30'h0, r_done, status_busy};
      c_idx_src_lo:  w_rd_data = r_src[31:0];
      c_idx_src_hi:  w_rd_data = r_src[63:32];
      c_idx_dst_lo:  w_rd_data = r_dst[31:0];
      c_idx_dst_hi:  w_rd_data = r_dst[63:32];
      c_idx_len:     w_rd_data = r_len;
      c_idx_version: w_rd_data = VERSION;
      c_idx_cnt:     w_rd_data = r_cycle_cnt;
`ifdef ROLE_CSR_SCRATCH_EN
      c_idx_scratch: w_rd_data = r_scratch;
`endif
      default: begin
        w_rd_data   = 32'h0;
        w_rd_mapped = 1'b0;
      end
    endcase
  end

  // Write channel FSM: AW and W are only ever accepted together.
  always_ff @(posedge CLK_IN_250) begin
    if (AXI_RESET) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= c_resp_okay;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (S_AXI_LITE_NORTH_FROM_STATIC.awvalid && S_AXI_LITE_NORTH_FROM_STATIC.wvalid) begin
            r_wstate  <= W_ACK;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        W_ACK: begin
          r_wstate  <= W_RESP;
          r_awready <= 1'b0;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b1;
          r_bresp   <= w_wr_mapped ? c_resp_okay : c_resp_slverr;
        end
        W_RESP: begin
          if (S_AXI_LITE_NORTH_FROM_STATIC.bready) begin
            r_wstate <= W_IDLE;
            r_bvalid <= 1'b0;
          end
        end
        default: begin
          r_wstate  <= W_IDLE;
          r_awready <= 1'b0;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Parameter registers: byte-enabled updates at the end of W_ACK.
  always_ff @(posedge CLK_IN_250) begin
    if (AXI_RESET) begin
      r_src <= 64'h0;
      r_dst <= 64'h0;
      r_len <= 32'h0;
    end else if (w_wr_commit) begin
      case (w_waddr_idx)
        c_idx_src_lo: r_src[31:0]  <= f_merge(r_src[31:0],  S_AXI_LITE_NORTH_FROM_STATIC.wdata, S_AXI_LITE_NORTH_FROM_STATIC.wstrb);
        c_idx_src_hi: r_src[63:32] <= f_merge(r_src[63:32], S_AXI_LITE_NORTH_FROM_STATIC.wdata, S_AXI_LITE_NORTH_FROM_STATIC.wstrb);
        c_idx_dst_lo: r_dst[31:0]  <= f_merge(r_dst[31:0],  S_AXI_LITE_NORTH_FROM_STATIC.wdata, S_AXI_LITE_NORTH_FROM_STATIC.wstrb);
        c_idx_dst_hi: r_dst[63:32] <= f_merge(r_dst[63:32], S_AXI_LITE_NORTH_FROM_STATIC.wdata, S_AXI_LITE_NORTH_FROM_STATIC.wstrb);
        c_idx_len:    r_len        <= f_merge(r_len,        S_AXI_LITE_NORTH_FROM_STATIC.wdata, S_AXI_LITE_NORTH_FROM_STATIC.wstrb);
        default: ;
      endcase
    end
  end

`ifdef ROLE_CSR_SCRATCH_EN
  // Scratch register for host-side bus sanity checks.
  always_ff @(posedge CLK_IN_250) begin
    if (AXI_RESET) begin
      r_scratch <= 32'h0;
    end else if (w_wr_commit && (w_waddr_idx == c_idx_scratch)) begin
      r_scratch <= f_merge(r_scratch, S_AXI_LITE_NORTH_FROM_STATIC.wdata, S_AXI_LITE_NORTH_FROM_STATIC.wstrb);
    end
  end
`endif

  // Start pulse and busy-cycle counter; a launched transfer restarts the count.
  always_ff @(posedge CLK_IN_250) begin
    if (AXI_RESET) begin
      r_start     <= 1'b0;
      r_cycle_cnt <= 32'h0;
    end else begin
      r_start <= w_start_req;
      if (w_start_req) begin
        r_cycle_cnt <= 32'h0;
      end else if (status_busy && (r_cycle_cnt != 32'hFFFF_FFFF)) begin
        r_cycle_cnt <= r_cycle_cnt + 32'h1;
      end
    end
  end

  // Sticky DONE flag; a completion in the same cycle as a clear keeps it set.
  always_ff @(posedge CLK_IN_250) begin
    if (AXI_RESET) begin
      r_done <= 1'b0;
    end else if (status_done) begin
      r_done <= 1'b1;
    end else if (w_done_clr) begin
      r_done <= 1'b0;
    end
  end

  // Read channel FSM: data is captured in R_ACK and held until rready.
  always_ff @(posedge CLK_IN_250) begin
    if (AXI_RESET) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= c_resp_okay;
      r_rdata   <= 32'h0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (S_AXI_LITE_NORTH_FROM_STATIC.arvalid) begin
            r_rstate  <= R_ACK;
            r_arready <= 1'b1;
          end
        end
        R_ACK: begin
          r_rstate  <= R_DATA;
          r_arready <= 1'b0;
          r_rvalid  <= 1'b1;
          r_rdata   <= w_rd_data;
          r_rresp   <= w_rd_mapped ? c_resp_okay : c_resp_slverr;
        end
        R_DATA: begin
          if (S_AXI_LITE_NORTH_FROM_STATIC.rready) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
          end
        end
        default: begin
          r_rstate  <= R_IDLE;
          r_arready <= 1'b0;
          r_rvalid  <= 1'b0;
        end
      endcase
    end
  end

  assign S_AXI_LITE_NORTH_FROM_STATIC.awready = r_awready;
  assign S_AXI_LITE_NORTH_FROM_STATIC.wready  = r_wready;
  assign S_AXI_LITE_NORTH_FROM_STATIC.bvalid  = r_bvalid;
  assign S_AXI_LITE_NORTH_FROM_STATIC.bresp   = r_bresp;
  assign S_AXI_LITE_NORTH_FROM_STATIC.arready = r_arready;
  assign S_AXI_LITE_NORTH_FROM_STATIC.rvalid  = r_rvalid;
  assign S_AXI_LITE_NORTH_FROM_STATIC.rresp   = r_rresp;
  assign S_AXI_LITE_NORTH_FROM_STATIC.rdata   = r_rdata;

  assign ctrl_start    = r_start;
  assign ctrl_src_addr = r_src;
  assign ctrl_dst_addr = r_dst;
  assign ctrl_len      = r_len;

endmodule
`default_nettype wire

// File: tb/tb_role_north_axil_csr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_role_north_axil_csr
// Brief    : Self-checking bench for role_north_axil_csr: directed vector
//            table, multi-cycle corner sequences and a randomized phase
//            against a register-map reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_role_north_axil_csr;

  localparam logic [31:0] C_VERSION = 32'h0001_0000;
`ifdef ROLE_CSR_SCRATCH_EN
  localparam bit C_SCR = 1'b1;
`else
  localparam bit C_SCR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        status_busy;
  logic        status_done;
  logic        ctrl_start;
  logic [63:0] ctrl_src_addr;
  logic [63:0] ctrl_dst_addr;
  logic [31:0] ctrl_len;

  int checks   = 0;
  int failures = 0;
  int start_cycles = 0;

  always #2 clk = ~clk;

  role_north_axil_csr_if bus ();

  role_north_axil_csr #(.VERSION(C_VERSION)) dut (
    .CLK_IN_250                   (clk),
    .AXI_RESET                    (rst),
    .S_AXI_LITE_NORTH_FROM_STATIC (bus),
    .ctrl_start                   (ctrl_start),
    .ctrl_src_addr                (ctrl_src_addr),
    .ctrl_dst_addr                (ctrl_dst_addr),
    .ctrl_len                     (ctrl_len),
    .status_busy                  (status_busy),
    .status_done                  (status_done)
  );

  always @(negedge clk) if (ctrl_start === 1'b1) start_cycles++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=handshake", name);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input bit done_in_ack, output logic [1:0] resp, output logic start_seen);
    int n;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    while (bus.awready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (bus.awready !== 1'b1) timeout("aw_ready");
    if (done_in_ack) status_done = 1'b1;
    @(posedge clk); #1;
    status_done = 1'b0;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    start_seen = ctrl_start;
    n = 0;
    while (bus.bvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (bus.bvalid !== 1'b1) timeout("b_valid");
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    bus.araddr = addr; bus.arvalid = 1'b1;
    n = 0;
    while (bus.arready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (bus.arready !== 1'b1) timeout("ar_ready");
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    n = 0;
    while (bus.rvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (bus.rvalid !== 1'b1) timeout("r_valid");
    data = bus.rdata; resp = bus.rresp;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mkv(bit wr, logic [31:0] addr, logic [31:0] data, logic [3:0] strb,
                               logic [1:0] resp, logic [31:0] rdata);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.resp = resp; v.rdata = rdata;
    return v;
  endfunction

  // Reference model of the register file (word index -> value).
  logic [31:0] m_reg [0:15];
  bit          m_done;

  function automatic bit m_mapped(int idx);
    return (idx <= 8) || (C_SCR && idx == 9);
  endfunction

  function automatic logic [31:0] m_read(int idx);
    case (idx)
      0: return 32'h0;
      1: return {30'h0, m_done, status_busy};
      7: return C_VERSION;
      8: return 32'h0;
      default: return m_mapped(idx) ? m_reg[idx] : 32'h0;
    endcase
  endfunction

  initial begin
    vec_t        vt [$];
    logic [1:0]  resp;
    logic [31:0] rd;
    logic        seen;
    int          s0;
    int          n;

    rst = 1'b1; status_busy = 1'b0; status_done = 1'b0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_handshakes", {60'h0, bus.awready, bus.arready, bus.bvalid, bus.rvalid}, 64'h0);
    chk("rst_ctrl_start", {63'h0, ctrl_start}, 64'h0);
    chk("rst_src", ctrl_src_addr, 64'h0);

    // ---------------- directed vector table ----------------
    vt.push_back(mkv(0, 32'h1C, 0, 0, 2'b00, C_VERSION));
    vt.push_back(mkv(0, 32'h20, 0, 0, 2'b00, 32'h0));
    vt.push_back(mkv(0, 32'h04, 0, 0, 2'b00, 32'h0));
    vt.push_back(mkv(0, 32'h00, 0, 0, 2'b00, 32'h0));
    vt.push_back(mkv(1, 32'h08, 32'hDEAD_BEEF, 4'b0101, 2'b00, 0));
    vt.push_back(mkv(0, 32'h08, 0, 0, 2'b00, 32'h00AD_00EF));
    vt.push_back(mkv(1, 32'h0C, 32'h1234_5678, 4'b1111, 2'b00, 0));
    vt.push_back(mkv(0, 32'h0C, 0, 0, 2'b00, 32'h1234_5678));
    vt.push_back(mkv(1, 32'h18, 32'hFFFF_1000, 4'b0011, 2'b00, 0));
    vt.push_back(mkv(0, 32'h18, 0, 0, 2'b00, 32'h0000_1000));
    vt.push_back(mkv(1, 32'h1C, 32'hFFFF_FFFF, 4'b1111, 2'b00, 0));
    vt.push_back(mkv(0, 32'h1C, 0, 0, 2'b00, C_VERSION));
    vt.push_back(mkv(1, 32'h20, 32'hFFFF_FFFF, 4'b1111, 2'b00, 0));
    vt.push_back(mkv(0, 32'h20, 0, 0, 2'b00, 32'h0));
    vt.push_back(mkv(1, 32'h40, 32'h5555_5555, 4'b1111, 2'b10, 0));
    vt.push_back(mkv(0, 32'h40, 0, 0, 2'b10, 32'h0));
    vt.push_back(mkv(1, 32'h24, 32'hA5A5_5A5A, 4'b1111, C_SCR ? 2'b00 : 2'b10, 0));
    vt.push_back(mkv(0, 32'h24, 0, 0, C_SCR ? 2'b00 : 2'b10, C_SCR ? 32'hA5A5_5A5A : 32'h0));

    foreach (vt[i]) begin
      if (vt[i].wr) begin
        axi_write(vt[i].addr, vt[i].data, vt[i].strb, 1'b0, resp, seen);
        chk($sformatf("vec%0d_bresp", i), {62'h0, resp}, {62'h0, vt[i].resp});
      end else begin
        axi_read(vt[i].addr, rd, resp);
        chk($sformatf("vec%0d_rresp", i), {62'h0, resp}, {62'h0, vt[i].resp});
        chk($sformatf("vec%0d_rdata", i), {32'h0, rd}, {32'h0, vt[i].rdata});
      end
    end
    chk("ctrl_src_addr", ctrl_src_addr, 64'h1234_5678_00AD_00EF);
    chk("ctrl_len", {32'h0, ctrl_len}, 64'h1000);

    // ---------------- START with idle datapath ----------------
    s0 = start_cycles;
    axi_write(32'h00, 32'h1, 4'hF, 1'b0, resp, seen);
    chk("start_at_n2", {63'h0, seen}, 64'h1);
    repeat (4) @(posedge clk);
    #1;
    chk("start_pulse_cycles", 64'(start_cycles - s0), 64'd1);

    status_busy = 1'b1;
    repeat (10) @(posedge clk);
    #1 status_busy = 1'b0;
    axi_read(32'h20, rd, resp);
    chk("cycle_cnt_10", {32'h0, rd}, 64'd10);

    // ---------------- START while busy ----------------
    status_busy = 1'b1;
    axi_read(32'h04, rd, resp);
    chk("status_busy_bit", {32'h0, rd}, 64'h1);
    s0 = start_cycles;
    axi_write(32'h00, 32'h1, 4'hF, 1'b0, resp, seen);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_start_nopulse", 64'(start_cycles - s0), 64'd0);
    chk("busy_start_bresp", {62'h0, resp}, 64'h0);
    status_busy = 1'b0;

    // ---------------- DONE set vs W1C collision ----------------
    axi_write(32'h04, 32'h2, 4'hF, 1'b1, resp, seen);
    axi_read(32'h04, rd, resp);
    chk("done_set_wins", {32'h0, rd}, 64'h2);
    axi_write(32'h04, 32'h2, 4'hF, 1'b0, resp, seen);
    axi_read(32'h04, rd, resp);
    chk("done_w1c", {32'h0, rd}, 64'h0);

    // ---------------- concurrent write+read with backpressure ----------------
    bus.awaddr = 32'h10; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.araddr = 32'h10;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    n = 0;
    while (!(bus.awready === 1'b1 && bus.arready === 1'b1) && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) timeout("concurrent_ready");
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold%0d_valids", c), {62'h0, bus.bvalid, bus.rvalid}, 64'h3);
      chk($sformatf("hold%0d_rdata_prewrite", c), {32'h0, bus.rdata}, 64'h0);
      @(posedge clk); #1;
    end
    chk("ctrl_dst_lo", {32'h0, ctrl_dst_addr[31:0]}, 64'hCAFE_F00D);
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    chk("hold_release", {62'h0, bus.bvalid, bus.rvalid}, 64'h0);
    axi_read(32'h10, rd, resp);
    chk("dst_lo_readback", {32'h0, rd}, 64'hCAFE_F00D);

    // ---------------- reset during pending B response ----------------
    status_done = 1'b1; @(posedge clk); #1; status_done = 1'b0;
    bus.awaddr = 32'h14; bus.wdata = 32'h1111_2222; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    while (bus.awready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("pre_reset_bvalid", {63'h0, bus.bvalid}, 64'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_drops_bvalid", {63'h0, bus.bvalid}, 64'h0);
    chk("reset_outputs", {ctrl_src_addr ^ ctrl_dst_addr, 31'h0, ctrl_start}, {64'h0, 32'h0});
    chk("reset_len", {32'h0, ctrl_len}, 64'h0);
    for (int idx = 0; idx <= 9; idx++) begin
      axi_read(32'(idx * 4), rd, resp);
      chk($sformatf("post_reset_rd%0d", idx), {32'h0, rd}, {32'h0, (idx == 7) ? C_VERSION : 32'h0});
    end

    // ---------------- randomized phase vs reference model ----------------
    for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
    m_done = 1'b0;
    for (int it = 0; it < 150; it++) begin
      int          r;
      int          idx;
      logic [31:0] tmp;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] mask;
      logic [3:0]  strb;
      r   = $urandom_range(0, 11);
      idx = (r == 11) ? 16 : r;
      tmp = $urandom();
      addr = (tmp & 32'hFFFF_FF03) | 32'(idx << 2);
      if ($urandom_range(0, 7) == 0) begin
        status_done = 1'b1; @(posedge clk); #1; status_done = 1'b0;
        m_done = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom();
        strb = 4'($urandom_range(0, 15));
        axi_write(addr, data, strb, 1'b0, resp, seen);
        chk($sformatf("rnd%0d_bresp_idx%0d", it, idx), {62'h0, resp},
            {62'h0, m_mapped(idx) ? 2'b00 : 2'b10});
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        if (idx == 1 && data[1]) m_done = 1'b0;
        if ((idx >= 2 && idx <= 6) || (C_SCR && idx == 9))
          m_reg[idx] = (m_reg[idx] & ~mask) | (data & mask);
      end else begin
        axi_read(addr, rd, resp);
        chk($sformatf("rnd%0d_rresp_idx%0d", it, idx), {62'h0, resp},
            {62'h0, m_mapped(idx) ? 2'b00 : 2'b10});
        chk($sformatf("rnd%0d_rdata_idx%0d", it, idx), {32'h0, rd}, {32'h0, m_read(idx)});
      end
    end
    chk("rnd_src_out", ctrl_src_addr, {m_reg[3], m_reg[2]});
    chk("rnd_dst_out", ctrl_dst_addr, {m_reg[5], m_reg[4]});
    chk("rnd_len_out", {32'h0, ctrl_len}, {32'h0, m_reg[6]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
